// File: rtl/calc_pkg.sv
// Shared types and constants for the keypad calculator sequencing controller.
package calc_pkg;

    typedef enum logic [2:0] {
        ST_ENTER_A = 3'd0,
        ST_ENTER_B = 3'd1,
        ST_CALC    = 3'd2,
        ST_RESULT  = 3'd3,
        ST_ERROR   = 3'd4
    } state_e;

    localparam logic [1:0] KEY_DIGIT = 2'd0;
    localparam logic [1:0] KEY_OP    = 2'd1;
    localparam logic [1:0] KEY_EQ    = 2'd2;
    localparam logic [1:0] KEY_CLR   = 2'd3;

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_MUL = 2'd2;
    localparam logic [1:0] OP_DIV = 2'd3;

    localparam logic [3:0] BCD_ERR = 4'hE;

endpackage

// File: rtl/bcd_digit_acc.sv
// One packed-BCD operand with its digit count; clear beats load beats shift-in.
module bcd_digit_acc #(
    parameter int unsigned NDIG = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          clr,
    input  logic                          load,
    input  logic [4*NDIG-1:0]             load_val,
    input  logic [$clog2(NDIG+1)-1:0]     load_cnt,
    input  logic                          shift,
    input  logic [3:0]                    digit,
    output logic [4*NDIG-1:0]             value,
    output logic [$clog2(NDIG+1)-1:0]     cnt
);

    localparam int unsigned W  = 4 * NDIG;
    localparam int unsigned CW = $clog2(NDIG + 1);

    // Digits past NDIG are dropped so the operand never loses its leading digits.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            value <= '0;
            cnt   <= '0;
        end else if (clr) begin
            value <= '0;
            cnt   <= '0;
        end else if (load) begin
            value <= load_val;
            cnt   <= load_cnt;
        end else if (shift && (cnt < CW'(NDIG))) begin
            value <= {value[W-5:0], digit};
            cnt   <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/calc_seq_ctrl.sv
// Keypad calculator sequencer: operand entry, ALU start/done handshake, display feed.
// Optional result chaining into a new operation is enabled by defining CALC_CHAIN_EN.
module calc_seq_ctrl
    import calc_pkg::*;
#(
    parameter int unsigned NDIG        = 4,
    parameter int unsigned ALU_TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                key_valid,
    input  logic [1:0]          key_class,
    input  logic [3:0]          key_code,
    output logic                alu_start,
    output logic [1:0]          alu_op,
    output logic [4*NDIG-1:0]   alu_a,
    output logic [4*NDIG-1:0]   alu_b,
    input  logic                alu_done,
    input  logic                alu_err,
    input  logic [4*NDIG-1:0]   alu_result,
    output logic [4*NDIG-1:0]   disp_value,
    output logic                disp_load,
    input  logic                disp_busy,
    output logic [2:0]          state_o,
    output logic                err
);

    localparam int unsigned W  = 4 * NDIG;
    localparam int unsigned CW = $clog2(NDIG + 1);
    localparam int unsigned TW = $clog2(ALU_TIMEOUT + 1);

    localparam logic [2:0] S_ENTER_A = ST_ENTER_A;
    localparam logic [2:0] S_ENTER_B = ST_ENTER_B;
    localparam logic [2:0] S_CALC    = ST_CALC;
    localparam logic [2:0] S_RESULT  = ST_RESULT;
    localparam logic [2:0] S_ERROR   = ST_ERROR;

    logic [2:0]    state, state_nx;
    logic [1:0]    op, op_nx;
    logic [W-1:0]  res, res_nx;
    logic [TW-1:0] tcnt;
    logic          pending;
    logic [W-1:0]  disp_nx;
    logic          start_nx, err_nx;

    logic          a_clr, a_load, a_shift, b_clr, b_shift;
    logic [W-1:0]  a_load_val;
    logic [CW-1:0] a_load_cnt;
    logic [W-1:0]  a_val, b_val;
    logic [CW-1:0] a_cnt, b_cnt;

    logic dig_ok, op_key, eq_key, clr_key;

    assign dig_ok  = key_valid && (key_class == KEY_DIGIT) && (key_code <= 4'd9);
    assign op_key  = key_valid && (key_class == KEY_OP);
    assign eq_key  = key_valid && (key_class == KEY_EQ);
    assign clr_key = key_valid && (key_class == KEY_CLR);

    bcd_digit_acc #(.NDIG(NDIG)) u_acc_a (
        .clk      (clk),
        .rst      (rst),
        .clr      (a_clr),
        .load     (a_load),
        .load_val (a_load_val),
        .load_cnt (a_load_cnt),
        .shift    (a_shift),
        .digit    (key_code),
        .value    (a_val),
        .cnt      (a_cnt)
    );

    bcd_digit_acc #(.NDIG(NDIG)) u_acc_b (
        .clk      (clk),
        .rst      (rst),
        .clr      (b_clr),
        .load     (1'b0),
        .load_val ('0),
        .load_cnt ('0),
        .shift    (b_shift),
        .digit    (key_code),
        .value    (b_val),
        .cnt      (b_cnt)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_ENTER_A;
        else      state <= state_nx;
    end

    // Next state plus operand/op/result controls; clear outranks everything, including alu_done.
    always_comb begin
        state_nx   = state;
        op_nx      = op;
        res_nx     = res;
        a_clr      = 1'b0;
        a_load     = 1'b0;
        a_load_val = W'(key_code);
        a_load_cnt = CW'(1);
        a_shift    = 1'b0;
        b_clr      = 1'b0;
        b_shift    = 1'b0;
        if (clr_key) begin
            a_clr    = 1'b1;
            b_clr    = 1'b1;
            op_nx    = OP_ADD;
            state_nx = S_ENTER_A;
        end else begin
            case (state)
                S_ENTER_A: begin
                    if (dig_ok) begin
                        a_shift = 1'b1;
                    end else if (op_key) begin
                        op_nx    = key_code[1:0];
                        b_clr    = 1'b1;
                        state_nx = S_ENTER_B;
                    end
                end
                S_ENTER_B: begin
                    if (dig_ok) begin
                        b_shift = 1'b1;
                    end else if (op_key) begin
                        if (b_cnt == '0) op_nx = key_code[1:0];
                    end else if (eq_key) begin
                        state_nx = S_CALC;
                    end
                end
                S_CALC: begin
                    // alu_done during the start cycle belongs to no request of ours.
                    if (alu_done && !alu_start) begin
                        if (alu_err) begin
                            state_nx = S_ERROR;
                        end else begin
                            res_nx   = alu_result;
                            state_nx = S_RESULT;
                        end
                    end else if (tcnt == TW'(ALU_TIMEOUT)) begin
                        state_nx = S_ERROR;
                    end
                end
                S_RESULT: begin
                    if (dig_ok) begin
                        a_load   = 1'b1;
                        b_clr    = 1'b1;
                        op_nx    = OP_ADD;
                        res_nx   = '0;
                        state_nx = S_ENTER_A;
                    end
`ifdef CALC_CHAIN_EN
                    else if (op_key) begin
                        a_load     = 1'b1;
                        a_load_val = res;
                        a_load_cnt = CW'(NDIG);
                        b_clr      = 1'b1;
                        op_nx      = key_code[1:0];
                        state_nx   = S_ENTER_B;
                    end
`endif
                end
                S_ERROR: ;
                default: state_nx = S_ENTER_A;
            endcase
        end
    end

    assign start_nx = (state_nx == S_CALC) && (state != S_CALC);
    assign err_nx   = (state_nx == S_ERROR);

    always_comb begin
        disp_nx = a_val;
        case (state)
            S_ENTER_B: if (b_cnt != '0) disp_nx = b_val;
            S_CALC:    disp_nx = b_val;
            S_RESULT:  disp_nx = res;
            S_ERROR:   disp_nx = {NDIG{BCD_ERR}};
            default:   ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op        <= OP_ADD;
            res       <= '0;
            alu_start <= 1'b0;
            err       <= 1'b0;
            tcnt      <= '0;
        end else begin
            op        <= op_nx;
            res       <= res_nx;
            alu_start <= start_nx;
            err       <= err_nx;
            if (start_nx)
                tcnt <= '0;
            else if ((state == S_CALC) && (tcnt != TW'(ALU_TIMEOUT)))
                tcnt <= tcnt + TW'(1);
        end
    end

    // Changes seen while the serializer is busy fold into a single later load.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            disp_value <= '0;
            disp_load  <= 1'b0;
            pending    <= 1'b1;
        end else begin
            disp_value <= disp_nx;
            if ((pending || (disp_nx != disp_value)) && !disp_busy) begin
                disp_load <= 1'b1;
                pending   <= 1'b0;
            end else begin
                disp_load <= 1'b0;
                pending   <= pending || (disp_nx != disp_value);
            end
        end
    end

    assign alu_a   = a_val;
    assign alu_b   = b_val;
    assign alu_op  = op;
    assign state_o = state;

endmodule
